inv_pattern_sequencer: RTL and testbench

//  Clocked test-pattern driver and checker for the CMOS inverter cell (my_not).

---
 rtl/inv_seq_pkg.sv | 27 ++
 rtl/inv_pat_mem.sv | 34 +++
 rtl/inv_pattern_sequencer.sv | 173 +++++++++++++++++
 tb/tb_inv_pattern_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_seq_pkg.sv
// Shared definitions for the inverter pattern sequencer.
//   - default sizing constants for the sequencer and its pattern memory
//   - sequencer state encoding
//   - pattern entry layout {level, hold}: level sits above the hold count
// No ports; imported by inv_pat_mem and inv_pattern_sequencer.
package inv_seq_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_HOLD_W = 8;
    localparam int DEF_CNT_W  = 8;

    // One pattern entry: level to drive, then how many cycles to hold it.
    localparam int ENTRY_W = 1 + DEF_HOLD_W;

    typedef struct packed {
        logic                  level;
        logic [DEF_HOLD_W-1:0] hold;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_DONE
    } state_t;

endpackage

// File: rtl/inv_pat_mem.sv
// Pattern memory for the inverter sequencer: DEPTH entries of W bits.
// Synchronous write, combinational read, contents are not reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   entry to store
//   raddr  in   read index
//   rdata  out  entry at raddr (combinational)
module inv_pat_mem
    import inv_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W     = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inv_pattern_sequencer.sv
// Clocked test-pattern driver and checker for the CMOS inverter cell.
// Plays a programmed list of {level, hold} entries onto the inverter input,
// samples the inverter output in the last cycle of each hold and counts
// mismatches against ~level, remembering the first failing entry.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   cfg_we/addr       write one pattern entry (ignored while busy)
//   cfg_level/hold    entry contents; a hold of 0 behaves as 1
//   cfg_len           entries to play, sampled on start, clamped to DEPTH
//   start             run request, only accepted in IDLE
//   drive_a           inverter input
//   sense_out         inverter output
//   busy              high from LOAD through the last HOLD
//   done              one-cycle pulse at the end of a run
//   err_count         saturating mismatch count for this run
//   err_flag          at least one mismatch this run
//   first_err_idx     index of the first mismatching entry
module inv_pattern_sequencer
    import inv_seq_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic                     cfg_level,
    input  logic [HOLD_W-1:0]        cfg_hold,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     start,
    output logic                     drive_a,
    input  logic                     sense_out,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         err_count,
    output logic                     err_flag,
    output logic [$clog2(DEPTH)-1:0] first_err_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = 1 + HOLD_W;

    state_t            state;
    state_t            state_next;
    logic [LW-1:0]     len;
    logic [AW-1:0]     idx;
    logic [HOLD_W-1:0] hold_cnt;

    logic [EW-1:0]     rd_entry;
    logic              rd_level;
    logic [HOLD_W-1:0] rd_hold;
    logic [LW-1:0]     len_clamped;
    logic              start_run;
    logic              sample;
    logic              last_entry;
    logic              mismatch;

    // Writes land in IDLE and DONE; the entry written in the same cycle as
    // an accepted start is already visible when LOAD reads it.
    inv_pat_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (cfg_we && !busy),
        .waddr (cfg_addr),
        .wdata ({cfg_level, cfg_hold}),
        .raddr (idx),
        .rdata (rd_entry)
    );

    assign rd_level    = rd_entry[HOLD_W];
    assign rd_hold     = rd_entry[HOLD_W-1:0];
    assign len_clamped = (cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : cfg_len;
    assign start_run   = (state == ST_IDLE) && start && (cfg_len != '0);
    // The last hold cycle of an entry is where the inverter output is judged.
    assign sample      = (state == ST_HOLD) && (hold_cnt == HOLD_W'(1));
    assign last_entry  = ({1'b0, idx} == (len - LW'(1)));
    assign mismatch    = (sense_out != ~drive_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length start skips straight to DONE so the requester still
    // sees its completion pulse.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (cfg_len != '0) ? ST_LOAD : ST_DONE;
                end
            end
            ST_LOAD: begin
                busy       = 1'b1;
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (sample) begin
                    state_next = last_entry ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: run setup, per-entry drive/hold load, and the error record.
    // Error outputs survive DONE and IDLE until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            len           <= '0;
            idx           <= '0;
            hold_cnt      <= '0;
            drive_a       <= 1'b0;
            err_count     <= '0;
            err_flag      <= 1'b0;
            first_err_idx <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_run) begin
                        len           <= len_clamped;
                        idx           <= '0;
                        err_count     <= '0;
                        err_flag      <= 1'b0;
                        first_err_idx <= '0;
                    end
                end
                ST_LOAD: begin
                    drive_a  <= rd_level;
                    hold_cnt <= (rd_hold == '0) ? HOLD_W'(1) : rd_hold;
                end
                ST_HOLD: begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                    if (sample) begin
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (!err_flag) begin
                                err_flag      <= 1'b1;
                                first_err_idx <= idx;
                            end
                        end
                        if (!last_entry) begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_pattern_sequencer.sv
// Self-checking bench for inv_pattern_sequencer.
// The inverter cell is modelled between drive_a and sense_out, with a mode
// that can pin its output low or high to provoke mismatches. A second
// instance with a 2-bit error counter always sees the wrong level.
module tb_inv_pattern_sequencer;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic       cfg_level;
    logic [7:0] cfg_hold;
    logic [3:0] cfg_len;
    logic       start;
    logic       drive_a;
    logic       sense_out;
    logic       busy;
    logic       done;
    logic [7:0] err_count;
    logic       err_flag;
    logic [2:0] first_err_idx;

    logic       sat_drive_a;
    logic       sat_sense_out;
    logic       sat_busy;
    logic       sat_done;
    logic [1:0] sat_err_count;
    logic       sat_err_flag;
    logic [2:0] sat_first_err_idx;

    // 0: healthy inverter, 1: output stuck low, 2: output stuck high
    logic [1:0] force_mode;

    int checks;
    int errors;

    // Bench copy of the pattern memory and the held error record.
    int sh_level [DEPTH];
    int sh_hold  [DEPTH];
    int m_err;
    int m_flag;
    int m_first;

    typedef struct {
        int len;
        int mode;
        bit poke;
        int lat;
        int err;
        int flag;
        int first;
    } vec_t;

    vec_t vecs [7];

    assign sense_out     = (force_mode == 2'd1) ? 1'b0 :
                           (force_mode == 2'd2) ? 1'b1 : ~drive_a;
    assign sat_sense_out = sat_drive_a;

    inv_pattern_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_level     (cfg_level),
        .cfg_hold      (cfg_hold),
        .cfg_len       (cfg_len),
        .start         (start),
        .drive_a       (drive_a),
        .sense_out     (sense_out),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .err_flag      (err_flag),
        .first_err_idx (first_err_idx)
    );

    inv_pattern_sequencer #(.CNT_W(2)) dut_sat (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_level     (cfg_level),
        .cfg_hold      (cfg_hold),
        .cfg_len       (cfg_len),
        .start         (start),
        .drive_a       (sat_drive_a),
        .sense_out     (sat_sense_out),
        .busy          (sat_busy),
        .done          (sat_done),
        .err_count     (sat_err_count),
        .err_flag      (sat_err_flag),
        .first_err_idx (sat_first_err_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkErrors(input string name, input int e, input int f, input int first);
        checkOutput({name, " err_count"}, int'(err_count), e);
        checkOutput({name, " err_flag"}, int'(err_flag), f);
        checkOutput({name, " first_err_idx"}, int'(first_err_idx), first);
    endtask

    task automatic writeEntry(input int addr, input int level, input int hold);
        cfg_we    = 1'b1;
        cfg_addr  = addr[2:0];
        cfg_level = level[0];
        cfg_hold  = hold[7:0];
        @(negedge clk);
        cfg_we        = 1'b0;
        sh_level[addr] = level;
        sh_hold[addr]  = hold;
    endtask

    // Expected run from the entry list: each entry takes one load cycle plus
    // its hold (minimum 1), done is sampled one edge after the last hold.
    // A mismatch is an inverter output equal to the level it was fed.
    function automatic void modelRun(input int len, input int mode, output int lat);
        int eff;
        int h;
        int sensed;
        eff = (len > DEPTH) ? DEPTH : len;
        lat = 1;
        if (eff != 0) begin
            m_err   = 0;
            m_flag  = 0;
            m_first = 0;
            for (int i = 0; i < eff; i++) begin
                h      = (sh_hold[i] == 0) ? 1 : sh_hold[i];
                sensed = (mode == 1) ? 0 : (mode == 2) ? 1 : 1 - sh_level[i];
                lat    = lat + 1 + h;
                if (sensed == sh_level[i]) begin
                    if (m_err < 255) m_err++;
                    if (m_flag == 0) begin
                        m_flag  = 1;
                        m_first = i;
                    end
                end
            end
        end
    endfunction

    // Starts a run from IDLE and follows it to completion. Latency is the
    // number of edges from the start edge to the edge that samples done.
    // With poke set, entry 3 is overwritten mid-run; the write must be lost.
    task automatic applyStimulus(input string name, input int len, input int mode,
                                 input bit poke, input int exp_lat);
        int eff;
        int lat;
        int s;
        int k;
        int h;
        bit busy_ok;
        bit prev_drive;
        eff        = (len > DEPTH) ? DEPTH : len;
        prev_drive = drive_a;
        force_mode = mode[1:0];
        cfg_len    = len[3:0];
        start      = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cfg_we  = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        s       = 0;
        k       = 0;
        for (int n = 0; n < 1000; n++) begin
            if (n > 0) @(negedge clk);
            cfg_we = 1'b0;
            if (poke && n == 2) begin
                cfg_we    = 1'b1;
                cfg_addr  = 3'd3;
                cfg_level = ~sh_level[3][0];
                cfg_hold  = 8'd99;
            end
            if (done) begin
                lat = n + 1;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (busy !== (n < exp_lat - 1)) busy_ok = 1'b0;
            if (k < eff && n == s + 1) begin
                checkOutput({name, " drive_a"}, int'(drive_a), sh_level[k]);
                h = (sh_hold[k] == 0) ? 1 : sh_hold[k];
                s = s + 1 + h;
                k++;
            end
        end
        cfg_we = 1'b0;
        checkOutput({name, " done latency"}, lat, exp_lat);
        checkOutput({name, " busy window"}, int'(busy_ok), 1);
        if (eff == 0) checkOutput({name, " drive_a held"}, int'(drive_a), int'(prev_drive));
        @(negedge clk);
        checkOutput({name, " done pulse width"}, int'(done), 0);
    endtask

    initial begin
        int lat;
        int len;
        int mode;
        int nwr;

        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_level  = 1'b0;
        cfg_hold   = '0;
        cfg_len    = '0;
        start      = 1'b0;
        force_mode = 2'd0;

        vecs[0] = '{4,  0, 1'b0, 55, 0, 0, 0};
        vecs[1] = '{4,  1, 1'b0, 55, 2, 1, 0};
        vecs[2] = '{4,  2, 1'b1, 55, 2, 1, 1};
        vecs[3] = '{0,  0, 1'b0, 1,  2, 1, 1};
        vecs[4] = '{8,  1, 1'b0, 66, 4, 1, 0};
        vecs[5] = '{15, 2, 1'b0, 66, 4, 1, 1};
        vecs[6] = '{5,  0, 1'b0, 57, 0, 0, 0};

        repeat (3) @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset drive_a", int'(drive_a), 0);
        checkErrors("reset", 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        writeEntry(0, 0, 10);
        writeEntry(1, 1, 15);
        writeEntry(2, 0, 20);
        writeEntry(3, 1, 5);
        writeEntry(4, 1, 0);
        writeEntry(5, 0, 3);
        writeEntry(6, 1, 2);
        writeEntry(7, 0, 1);

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode,
                          vecs[i].poke, vecs[i].lat);
            checkErrors($sformatf("vec%0d", i), vecs[i].err, vecs[i].flag, vecs[i].first);
        end
        checkOutput("sat err_count", int'(sat_err_count), 3);
        checkOutput("sat err_flag", int'(sat_err_flag), 1);
        checkOutput("sat first_err_idx", int'(sat_first_err_idx), 0);

        // Zero-hold entry written in the same cycle as the start.
        cfg_we      = 1'b1;
        cfg_addr    = 3'd0;
        cfg_level   = 1'b1;
        cfg_hold    = 8'd0;
        sh_level[0] = 1;
        sh_hold[0]  = 0;
        applyStimulus("zero hold", 1, 0, 1'b0, 3);
        checkErrors("zero hold", 0, 0, 0);
        writeEntry(0, 0, 10);

        // Reset in the middle of entry 2's hold, then replay untouched memory.
        force_mode = 2'd1;
        cfg_len    = 4'd4;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("pre-reset busy", int'(busy), 1);
        checkOutput("pre-reset err_count", int'(err_count), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid-run reset busy", int'(busy), 0);
        checkOutput("mid-run reset done", int'(done), 0);
        checkOutput("mid-run reset drive_a", int'(drive_a), 0);
        checkErrors("mid-run reset", 0, 0, 0);
        rst        = 1'b0;
        force_mode = 2'd0;
        @(negedge clk);
        applyStimulus("replay", 4, 0, 1'b0, 55);
        checkErrors("replay", 0, 0, 0);

        m_err   = 0;
        m_flag  = 0;
        m_first = 0;
        for (int r = 0; r < 10; r++) begin
            nwr = $urandom_range(3, 0);
            for (int w = 0; w < nwr; w++) begin
                writeEntry($urandom_range(7, 0), $urandom_range(1, 0), $urandom_range(12, 0));
            end
            len  = $urandom_range(10, 0);
            mode = $urandom_range(2, 0);
            modelRun(len, mode, lat);
            applyStimulus($sformatf("rand%0d", r), len, mode, 1'b0, lat);
            checkErrors($sformatf("rand%0d", r), m_err, m_flag, m_first);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
